// File: rtl/axi_line_master_pkg.sv
// rtl/axi_line_master_pkg.sv - shared types, AXI encodings and widths for axi_line_master
package axi_master_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_LEN_W  = 4;
  localparam int unsigned AXI_STRB_W = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_RSP
  } state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_t;

  // Lines align to the full line size so the INCR burst never crosses a line.
  function automatic logic [AXI_ADDR_W-1:0] align_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                       input logic                  line,
                                                       input int unsigned           line_words);
    logic [AXI_ADDR_W-1:0] mask;
    mask = line ? AXI_ADDR_W'(~((line_words * 4) - 1)) : {{(AXI_ADDR_W-2){1'b1}}, 2'b00};
    return addr & mask;
  endfunction

endpackage

// File: rtl/axi_line_master_if.sv
// rtl/axi_line_master_if.sv - AXI4 five-channel bundle between axi_line_master and the interconnect
interface axi_line_master_if;
  import axi_master_pkg::*;

  logic [AXI_ID_W-1:0]   AWID_M;
  logic [AXI_ADDR_W-1:0] AWADDR_M;
  logic [AXI_LEN_W-1:0]  AWLEN_M;
  logic [2:0]            AWSIZE_M;
  logic [1:0]            AWBURST_M;
  logic                  AWVALID_M;
  logic                  AWREADY_M;

  logic [AXI_DATA_W-1:0] WDATA_M;
  logic [AXI_STRB_W-1:0] WSTRB_M;
  logic                  WLAST_M;
  logic                  WVALID_M;
  logic                  WREADY_M;

  logic [AXI_ID_W-1:0]   BID_M;
  logic [1:0]            BRESP_M;
  logic                  BVALID_M;
  logic                  BREADY_M;

  logic [AXI_ID_W-1:0]   ARID_M;
  logic [AXI_ADDR_W-1:0] ARADDR_M;
  logic [AXI_LEN_W-1:0]  ARLEN_M;
  logic [2:0]            ARSIZE_M;
  logic [1:0]            ARBURST_M;
  logic                  ARVALID_M;
  logic                  ARREADY_M;

  logic [AXI_ID_W-1:0]   RID_M;
  logic [AXI_DATA_W-1:0] RDATA_M;
  logic [1:0]            RRESP_M;
  logic                  RLAST_M;
  logic                  RVALID_M;
  logic                  RREADY_M;

  modport master (
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M,
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M
  );

  modport slave (
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M,
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M
  );

endinterface

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - single-outstanding AXI4 master: word read/write or INCR line refill/writeback
module axi_line_master
  import axi_master_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] MASTER_ID  = 4'd0,
  parameter int unsigned         LINE_WORDS = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_line,
  input  logic [AXI_ADDR_W-1:0]     req_addr,
  input  logic [32*LINE_WORDS-1:0]  req_wdata,
  input  logic [AXI_STRB_W-1:0]     req_wstrb,
  output logic                      rsp_valid,
  output logic [32*LINE_WORDS-1:0]  rsp_rdata,
  output logic                      rsp_err,
  axi_line_master_if.master         axi
);

  localparam int unsigned IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [AXI_LEN_W-1:0] LINE_LEN = AXI_LEN_W'(LINE_WORDS - 1);

  state_t                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  err_q;
  logic                  line_q;
  logic [4:0]            beat_q;
  logic [AXI_LEN_W-1:0]  len_q;
  logic [AXI_STRB_W-1:0] wstrb_q;
  logic [31:0]           wword_q [LINE_WORDS];
  logic [31:0]           rdata_q [LINE_WORDS];
  ax_t                   ar_q;
  ax_t                   aw_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic [31:0]           wdata_q;
  logic [AXI_STRB_W-1:0] wstrb_out_q;

  ax_t        ax_d;
  logic       accept;
  logic       last_beat;
  logic [4:0] beat_nxt;
  logic       r_err_d;
  logic       b_err_d;
  logic       unused_ids;

  assign accept    = (state_q == S_IDLE) && req_ready_q && req_valid;
  assign last_beat = (beat_q == {1'b0, len_q});
  // Saturate so a runaway overrun burst can never wrap back into the line.
  assign beat_nxt  = (beat_q == 5'd31) ? beat_q : beat_q + 5'd1;

  always_comb begin
    ax_d       = '0;
    ax_d.id    = MASTER_ID;
    ax_d.addr  = align_addr(req_addr, req_line, LINE_WORDS);
    ax_d.len   = req_line ? LINE_LEN : '0;
    ax_d.size  = SIZE_WORD;
    ax_d.burst = BURST_INCR;
  end

  // RLAST must coincide exactly with the expected last beat; either mismatch is an error.
  assign r_err_d = err_q | (axi.RRESP_M != RESP_OKAY) | (axi.RLAST_M != last_beat);
  assign b_err_d = err_q | (axi.BRESP_M != RESP_OKAY);

  assign unused_ids = ^{axi.RID_M, axi.BID_M};

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rdata
    assign rsp_rdata[32*g +: 32] = rdata_q[g];
  end

  assign axi.ARID_M    = ar_q.id;
  assign axi.ARADDR_M  = ar_q.addr;
  assign axi.ARLEN_M   = ar_q.len;
  assign axi.ARSIZE_M  = ar_q.size;
  assign axi.ARBURST_M = ar_q.burst;
  assign axi.ARVALID_M = arvalid_q;
  assign axi.RREADY_M  = rready_q;
  assign axi.AWID_M    = aw_q.id;
  assign axi.AWADDR_M  = aw_q.addr;
  assign axi.AWLEN_M   = aw_q.len;
  assign axi.AWSIZE_M  = aw_q.size;
  assign axi.AWBURST_M = aw_q.burst;
  assign axi.AWVALID_M = awvalid_q;
  assign axi.WDATA_M   = wdata_q;
  assign axi.WSTRB_M   = wstrb_out_q;
  assign axi.WLAST_M   = wlast_q;
  assign axi.WVALID_M  = wvalid_q;
  assign axi.BREADY_M  = bready_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_q       <= 1'b0;
      line_q      <= 1'b0;
      beat_q      <= '0;
      len_q       <= '0;
      wstrb_q     <= '0;
      ar_q        <= '0;
      aw_q        <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_out_q <= '0;
      for (int i = 0; i < int'(LINE_WORDS); i++) begin
        wword_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            err_q       <= 1'b0;
            line_q      <= req_line;
            len_q       <= ax_d.len;
            beat_q      <= '0;
            wstrb_q     <= req_wstrb;
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
              wword_q[i] <= req_wdata[32*i +: 32];
            end
            if (req_write) begin
              aw_q      <= ax_d;
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end else begin
              ar_q      <= ax_d;
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end

        S_AR: begin
          if (axi.ARREADY_M) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_R;
          end
        end

        S_R: begin
          if (axi.RVALID_M) begin
            if (beat_q <= {1'b0, len_q}) begin
              rdata_q[beat_q[IDX_W-1:0]] <= axi.RDATA_M;
            end
            beat_q <= beat_nxt;
            err_q  <= r_err_d;
            if (axi.RLAST_M) begin
              rready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= r_err_d;
              state_q     <= S_RSP;
            end
          end
        end

        S_AW: begin
          if (axi.AWREADY_M) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b1;
            wdata_q     <= wword_q[0];
            wstrb_out_q <= line_q ? 4'hF : wstrb_q;
            wlast_q     <= (len_q == '0);
            beat_q      <= '0;
            state_q     <= S_W;
          end
        end

        S_W: begin
          if (axi.WREADY_M) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_B;
            end else begin
              beat_q  <= beat_nxt;
              wdata_q <= wword_q[beat_nxt[IDX_W-1:0]];
              wlast_q <= (beat_nxt == {1'b0, len_q});
            end
          end
        end

        S_B: begin
          if (axi.BVALID_M) begin
            bready_q    <= 1'b0;
            err_q       <= b_err_d;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= b_err_d;
            state_q     <= S_RSP;
          end
        end

        S_RSP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
